// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for a simple dual-port RAM with a registered read port; a 2-entry skid buffer
// hides the read latency. Optional fill-level outputs are enabled by defining RAM_FIFO_LEVEL_EN.
module ram_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] inData,
  input  logic                  inValid,
  output logic                  inReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  ramWriteEnabled,
  output logic [ADDR_WIDTH-1:0] ramWriteAddr,
  output logic [DATA_WIDTH-1:0] ramData,
  output logic [ADDR_WIDTH-1:0] ramReadAddr,
  input  logic [DATA_WIDTH-1:0] ramQ
`ifdef RAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  almostFull
`endif
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(Depth);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
  logic                  rd_pending_q;
  logic [DATA_WIDTH-1:0] skid0_q, skid0_d;
  logic [DATA_WIDTH-1:0] skid1_q, skid1_d;
  logic [1:0]            skid_count_q, skid_count_d;

  logic       push_fire;
  logic       pop_fire;
  logic       rd_fire;
  logic [2:0] skid_occ;

  assign inReady   = rst_n & (ram_count_q < DepthCnt);
  assign push_fire = inValid & inReady;
  assign outValid  = (skid_count_q != 2'd0);
  assign outData   = skid0_q;
  assign pop_fire  = outValid & outReady;

  // Skid slots already claimed after this edge: held words plus the word in flight from the RAM.
  assign skid_occ = {1'b0, skid_count_q} + {2'b0, rd_pending_q} - {2'b0, pop_fire};
  assign rd_fire  = (ram_count_q != '0) & (skid_occ < 3'd2);

  assign ramWriteEnabled = push_fire;
  assign ramWriteAddr    = wr_ptr_q;
  assign ramData         = inData;
  assign ramReadAddr     = rd_ptr_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    if (push_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_fire && !rd_fire) begin
      ram_count_d = ram_count_q + 1'b1;
    end else if (!push_fire && rd_fire) begin
      ram_count_d = ram_count_q - 1'b1;
    end
  end

  always_comb begin
    skid0_d      = skid0_q;
    skid1_d      = skid1_q;
    skid_count_d = skid_count_q;
    if (pop_fire) begin
      // A lone head is left in place so outData holds its last value once empty.
      if (skid_count_q == 2'd2) begin
        skid0_d = skid1_q;
      end
      skid_count_d = skid_count_q - 1'b1;
    end
    if (rd_pending_q) begin
      if (skid_count_d == 2'd0) begin
        skid0_d = ramQ;
      end else begin
        skid1_d = ramQ;
      end
      skid_count_d = skid_count_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_count_q  <= '0;
      rd_pending_q <= 1'b0;
      skid0_q      <= '0;
      skid1_q      <= '0;
      skid_count_q <= 2'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_count_q  <= ram_count_d;
      rd_pending_q <= rd_fire;
      skid0_q      <= skid0_d;
      skid1_q      <= skid1_d;
      skid_count_q <= skid_count_d;
    end
  end

`ifdef RAM_FIFO_LEVEL_EN
  localparam logic [ADDR_WIDTH:0] AlmostFullCnt = (ADDR_WIDTH + 1)'(Depth - 2);

  logic [ADDR_WIDTH+1:0] level_q, level_d;

  assign level_d = {1'b0, ram_count_d} + {{(ADDR_WIDTH + 1){1'b0}}, rd_fire}
                 + {{ADDR_WIDTH{1'b0}}, skid_count_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level      = level_q;
  assign almostFull = (ram_count_q >= AlmostFullCnt);
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural registered-read dual-port RAM.
module tb_ram_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] inData;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] outData;
  logic          outValid;
  logic          outReady;
  logic          ramWriteEnabled;
  logic [AW-1:0] ramWriteAddr;
  logic [DW-1:0] ramData;
  logic [AW-1:0] ramReadAddr;
  logic [DW-1:0] ramQ;
`ifdef RAM_FIFO_LEVEL_EN
  logic [AW+1:0] level;
  logic          almostFull;
`endif

  always #5 clk = ~clk;

  ram_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inData         (inData),
    .inValid        (inValid),
    .inReady        (inReady),
    .outData        (outData),
    .outValid       (outValid),
    .outReady       (outReady),
    .ramWriteEnabled(ramWriteEnabled),
    .ramWriteAddr   (ramWriteAddr),
    .ramData        (ramData),
    .ramReadAddr    (ramReadAddr),
    .ramQ           (ramQ)
`ifdef RAM_FIFO_LEVEL_EN
    ,
    .level          (level),
    .almostFull     (almostFull)
`endif
  );

  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (ramWriteEnabled) mem[ramWriteAddr] <= ramData;
    ramQ <= mem[ramReadAddr];
  end

  int            checks = 0;
  int            errors = 0;
  int            pops = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_wa = '0;
  logic          stream_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: records accepted pushes, checks write addressing and every popped word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (inValid && inReady) exp_q.push_back(inData);
      if (ramWriteEnabled || (inValid && inReady)) begin
        chk("ram_we", 32'(ramWriteEnabled), 32'(inValid && inReady));
        chk("ram_waddr", 32'(ramWriteAddr), 32'(exp_wa));
        exp_wa = exp_wa + 1'b1;
      end
      if (outValid && outReady) begin
        pops++;
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 32'(outData), 32'hFFFF_FFFF);
        end else begin
          chk("pop_data", 32'(outData), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic wait_empty(input string name, input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int            w;
    int            guard;
    int            pops0;
    logic          fired;
    rst_n       = 1'b0;
    inData      = '0;
    inValid     = 1'b0;
    outReady    = 1'b0;
    stream_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inready", 32'(inReady), 32'd0);
    chk("rst_outvalid", 32'(outValid), 32'd0);
    chk("rst_outdata", 32'(outData), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_inready", 32'(inReady), 32'd1);
    chk("idle_outvalid", 32'(outValid), 32'd0);
    chk("idle_we", 32'(ramWriteEnabled), 32'd0);
    chk("idle_raddr", 32'(ramReadAddr), 32'd0);

    // Single word latency: push at edge 0, visible after edge 2, popped at edge 3.
    @(posedge clk); #1;
    outReady = 1'b1;
    inValid  = 1'b1;
    inData   = 8'hA5;
    #1;
    chk("a5_we", 32'(ramWriteEnabled), 32'd1);
    chk("a5_waddr", 32'(ramWriteAddr), 32'd0);
    chk("a5_wdata", 32'(ramData), 32'hA5);
    @(posedge clk); #1;
    inValid = 1'b0;
    chk("a5_lat_e0", 32'(outValid), 32'd0);
    @(posedge clk); #1;
    chk("a5_lat_e1", 32'(outValid), 32'd0);
    @(posedge clk); #1;
    chk("a5_lat_e2_valid", 32'(outValid), 32'd1);
    chk("a5_lat_e2_data", 32'(outData), 32'hA5);
    @(posedge clk); #1;
    chk("a5_after_pop", 32'(outValid), 32'd0);

    // Fill to DEPTH+2 words with the sink stalled.
    outReady = 1'b0;
    for (int i = 0; i < 66; i++) begin
      inValid = 1'b1;
      inData  = 8'(i);
      if (i == 65) chk("fill_last_ready", 32'(inReady), 32'd1);
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    chk("full_inready", 32'(inReady), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    inValid = 1'b1;
    inData  = 8'hFF;
    #1;
    chk("full_push_we", 32'(ramWriteEnabled), 32'd0);
    chk("full_head_valid", 32'(outValid), 32'd1);
    chk("full_head_data", 32'(outData), 32'h00);
    @(posedge clk); #1;
    inValid = 1'b0;

    // Drain at full rate: 66 consecutive valid cycles, then empty.
    outReady = 1'b1;
    pops0 = pops;
    for (int i = 0; i < 66; i++) begin
      @(negedge clk);
      chk("drain_valid", 32'(outValid), 32'd1);
    end
    @(negedge clk);
    chk("drain_empty", 32'(outValid), 32'd0);
    chk("drain_count", 32'(pops - pops0), 32'd66);
    chk("drain_outdata_hold", 32'(outData), 32'd65);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);

    // Random-rate concurrent streaming of 200 words.
    @(posedge clk); #1;
    pops0 = pops;
    fork
      begin
        w = 0;
        guard = 0;
        while (w < 200 && guard < 5000) begin
          guard++;
          if ($urandom_range(0, 3) == 0) begin
            inValid = 1'b0;
            @(posedge clk); #1;
          end else begin
            inValid = 1'b1;
            inData  = 8'(w + 7);
            @(negedge clk);
            fired = inReady;
            @(posedge clk); #1;
            inValid = 1'b0;
            if (fired) w++;
          end
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          outReady = 1'($urandom_range(0, 1));
        end
      end
    join
    chk("stream_pushed", 32'(w), 32'd200);
    outReady = 1'b1;
    wait_empty("stream_drained", 300);
    chk("stream_pops", 32'(pops - pops0), 32'd200);

    // Reset with 10 words held drops them; a fresh push comes out first.
    @(posedge clk); #1;
    outReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      inValid = 1'b1;
      inData  = 8'(8'h40 + i);
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_valid", 32'(outValid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", 32'(outValid), 32'd0);
    chk("mid_reset_inready", 32'(inReady), 32'd0);
    exp_q.delete();
    exp_wa = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b1;
    inValid  = 1'b1;
    inData   = 8'h3C;
    @(posedge clk); #1;
    inValid = 1'b0;
    wait_empty("post_reset_3c", 20);
    repeat (2) @(posedge clk);
    #1;
    chk("final_empty", 32'(outValid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
